// File: rtl/stats_display_scanner_if.sv
// Bundles the statistics counters, display control and seven-segment pins of stats_display_scanner.
// The master modport is the statistics/board side and the slave modport is the scanner.
interface stats_display_scanner_if;
  logic [15:0] nocondition_num;
  logic [15:0] condition_num;
  logic [15:0] condition_success_num;
  logic        halt_sign;
  logic [1:0]  sel;
  logic [7:0]  an;
  logic [7:0]  seg;

  modport master (
    output nocondition_num, condition_num, condition_success_num, halt_sign, sel,
    input  an, seg
  );

  modport slave (
    input  nocondition_num, condition_num, condition_success_num, halt_sign, sel,
    output an, seg
  );
endinterface

// File: rtl/stats_display_scanner.sv
// Snapshots one branch-statistics counter and scans it onto an 8-digit seven-segment display as "C<n>  XXXX".
// Optional macro STATS_DISP_AUTO_ROTATE_EN: ignore sel and cycle through the three counters every ROTATE_FRAMES frames.
module stats_display_scanner #(
  parameter int SCAN_DIV      = 50000,
  parameter int ROTATE_FRAMES = 250
) (
  input  logic                   clk,
  input  logic                   RST,
  stats_display_scanner_if.slave bus
);
  localparam int DIV_W = $clog2(SCAN_DIV);

  if (SCAN_DIV < 2 || ROTATE_FRAMES < 1) begin : g_paramCheck
    $error("stats_display_scanner: SCAN_DIV must be >= 2 and ROTATE_FRAMES >= 1");
  end

  logic [DIV_W-1:0] r_divCnt;
  logic [2:0]       r_digit;
  logic             r_live;
  logic [1:0]       r_selQ;
  logic [15:0]      r_snap0;
  logic [15:0]      r_snap1;
  logic [15:0]      r_snap2;
  logic [7:0]       r_an;
  logic [7:0]       r_seg;
  logic             w_tick;
  logic             w_frameEnd;
  logic [15:0]      w_value;
  logic [3:0]       w_nibble;
  logic [7:0]       w_seg;

  function automatic logic [6:0] hexFont(input logic [3:0] n);
    case (n)
      4'h0: hexFont = 7'h40;
      4'h1: hexFont = 7'h79;
      4'h2: hexFont = 7'h24;
      4'h3: hexFont = 7'h30;
      4'h4: hexFont = 7'h19;
      4'h5: hexFont = 7'h12;
      4'h6: hexFont = 7'h02;
      4'h7: hexFont = 7'h78;
      4'h8: hexFont = 7'h00;
      4'h9: hexFont = 7'h10;
      4'hA: hexFont = 7'h08;
      4'hB: hexFont = 7'h03;
      4'hC: hexFont = 7'h46;
      4'hD: hexFont = 7'h21;
      4'hE: hexFont = 7'h06;
      default: hexFont = 7'h0E;
    endcase
  endfunction

  assign w_tick     = (r_divCnt == DIV_W'(SCAN_DIV - 1));
  assign w_frameEnd = w_tick && r_live && (r_digit == 3'd7);

  // The first tick after reset lights digit 0 without advancing, so every frame starts at d0.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_divCnt <= '0;
      r_digit  <= 3'd0;
      r_live   <= 1'b0;
    end else begin
      r_divCnt <= w_tick ? '0 : r_divCnt + 1'b1;
      if (w_tick) begin
        r_live <= 1'b1;
        if (r_live) r_digit <= r_digit + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_snap0 <= 16'h0000;
      r_snap1 <= 16'h0000;
      r_snap2 <= 16'h0000;
    end else if (bus.halt_sign) begin
      r_snap0 <= bus.nocondition_num;
      r_snap1 <= bus.condition_num;
      r_snap2 <= bus.condition_success_num;
    end
  end

`ifdef STATS_DISP_AUTO_ROTATE_EN
  localparam int ROT_W = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;
  logic [ROT_W-1:0] r_rotCnt;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_selQ   <= 2'd0;
      r_rotCnt <= '0;
    end else if (w_frameEnd) begin
      if (r_rotCnt == ROT_W'(ROTATE_FRAMES - 1)) begin
        r_rotCnt <= '0;
        r_selQ   <= (r_selQ == 2'd2) ? 2'd0 : r_selQ + 2'd1;
      end else begin
        r_rotCnt <= r_rotCnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (RST)             r_selQ <= 2'd0;
    else if (w_frameEnd) r_selQ <= bus.sel;
  end
`endif

  always_comb begin
    w_value  = r_snap2;
    w_nibble = 4'h0;
    w_seg    = 8'hFF;
    case (r_selQ)
      2'd0:    w_value = r_snap0;
      2'd1:    w_value = r_snap1;
      default: w_value = r_snap2;
    endcase
    case (r_digit[1:0])
      2'd0:    w_nibble = w_value[3:0];
      2'd1:    w_nibble = w_value[7:4];
      2'd2:    w_nibble = w_value[11:8];
      default: w_nibble = w_value[15:12];
    endcase
    if (r_selQ == 2'd3) begin
      w_seg = 8'hBF;
    end else begin
      case (r_digit)
        3'd4, 3'd5: w_seg = 8'hFF;
        3'd6:       w_seg = {1'b1, hexFont({2'b00, r_selQ})};
        3'd7:       w_seg = {1'b1, hexFont(4'hC)};
        default:    w_seg = {1'b1, hexFont(w_nibble)};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_an  <= 8'hFF;
      r_seg <= 8'hFF;
    end else if (r_live) begin
      r_an  <= ~(8'b1 << r_digit);
      r_seg <= w_seg;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
endmodule

// File: tb/tb_stats_display_scanner.sv
// Scoreboard bench for stats_display_scanner: expected digits are queued per frame and compared as each new digit lights.
module tb_stats_display_scanner;
  localparam int SCAN_DIV      = 4;
  localparam int ROTATE_FRAMES = 2;

  logic clk = 1'b0;
  logic RST;
  stats_display_scanner_if bus ();

  stats_display_scanner #(.SCAN_DIV(SCAN_DIV), .ROTATE_FRAMES(ROTATE_FRAMES)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } expT;

  expT        sbQ[$];
  expT        sbHead;
  int         checks = 0;
  int         errors = 0;
  bit         monitorOn = 1'b0;
  logic [7:0] prevAn = 8'hFF;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] fontOf(input int n);
    logic [6:0] table7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return table7[n];
  endfunction

  function automatic logic [15:0] expDigit(input int d, input int n, input logic [15:0] v);
    logic [7:0] an;
    logic [7:0] seg;
    an = ~(8'b1 << d);
    if (n == 3)      seg = 8'hBF;
    else if (d < 4)  seg = {1'b1, fontOf(int'((v >> (4 * d)) & 16'hF))};
    else if (d < 6)  seg = 8'hFF;
    else if (d == 6) seg = {1'b1, fontOf(n)};
    else             seg = {1'b1, fontOf(12)};
    return {an, seg};
  endfunction

  task automatic expectFrame(input string name, input int n, input logic [15:0] v, input int nDigits);
    expT e;
    for (int d = 0; d < nDigits; d++) begin
      e.tag = $sformatf("%s_d%0d", name, d);
      e.val = expDigit(d, n, v);
      sbQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                               input logic h, input logic [1:0] s);
    bus.nocondition_num       = a;
    bus.condition_num         = b;
    bus.condition_success_num = c;
    bus.halt_sign             = h;
    bus.sel                   = s;
  endtask

  task automatic waitAn(input logic [7:0] target, input string tag);
    int n = 0;
    while (bus.an !== target && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {8'h00, bus.an}, {8'h00, target});
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    monitorOn = 1'b0;
    checkOutput("sb_drain", 16'(sbQ.size()), 16'd0);
  endtask

  always @(negedge clk) begin
    if (monitorOn && bus.an !== prevAn && bus.an !== 8'hFF) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected", {bus.an, bus.seg}, 16'hFFFF);
      end else begin
        sbHead = sbQ.pop_front();
        checkOutput(sbHead.tag, {bus.an, bus.seg}, sbHead.val);
      end
    end
    prevAn = bus.an;
  end

  initial begin
`ifdef STATS_DISP_AUTO_ROTATE_EN
    applyStimulus(16'h1234, 16'h0005, 16'hABCD, 1'b1, 2'd3);
`else
    applyStimulus(16'h1234, 16'h0005, 16'hABCD, 1'b1, 2'd0);
`endif
    RST = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_an", {8'h00, bus.an}, 16'h00FF);
    checkOutput("reset_seg", {8'h00, bus.seg}, 16'h00FF);

`ifdef STATS_DISP_AUTO_ROTATE_EN
    expectFrame("r1", 0, 16'h1234, 8);
    expectFrame("r2", 0, 16'h1234, 8);
    expectFrame("r3", 1, 16'h0005, 8);
    expectFrame("r4", 1, 16'h0005, 8);
    expectFrame("r5", 2, 16'hABCD, 8);
    expectFrame("r6", 2, 16'hABCD, 8);
    expectFrame("r7", 0, 16'h1234, 8);
`else
    expectFrame("f1", 0, 16'h1234, 8);
    expectFrame("f2", 2, 16'hABCD, 8);
`endif
    monitorOn = 1'b1;
    RST = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("dark_before_tick", {8'h00, bus.an}, 16'h00FF);
    @(negedge clk);
    checkOutput("first_an", {8'h00, bus.an}, 16'h00FE);

`ifndef STATS_DISP_AUTO_ROTATE_EN
    // sel changes mid-frame must wait for the frame boundary.
    waitAn(8'hF7, "wait_f1_d3");
    bus.sel = 2'd2;

    waitAn(8'hFD, "wait_f2_d1");
    applyStimulus(16'h1111, 16'h2222, 16'h9E7F, 1'b0, 2'd2);
    expectFrame("f3", 2, 16'hABCD, 8);

    waitAn(8'hFE, "wait_f3_d0");
    waitAn(8'hDF, "wait_f3_d5");
    bus.halt_sign = 1'b1;
    expectFrame("f4", 2, 16'h9E7F, 8);

    waitAn(8'hFE, "wait_f4_d0");
    waitAn(8'hFB, "wait_f4_d2");
    bus.sel = 2'd3;
    expectFrame("f5", 3, 16'h0000, 6);

    // Reset mid-frame with capture held, so the zeroed snapshots stay visible.
    waitAn(8'hFE, "wait_f5_d0");
    waitAn(8'hDF, "wait_f5_d5");
    bus.halt_sign = 1'b0;
    RST = 1'b1;
    expectFrame("f6", 0, 16'h0000, 8);
    expectFrame("f7", 3, 16'h0000, 8);
    @(negedge clk);
    checkOutput("rst_pulse_an", {8'h00, bus.an}, 16'h00FF);
    checkOutput("rst_pulse_seg", {8'h00, bus.seg}, 16'h00FF);
    RST = 1'b0;
`endif

    waitDrain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
